// File: rtl/lab61soc_pio_poll_master_pkg.sv
// ============================================================================
// Module : lab61soc_pio_pkg
// Brief  : Shared types, bus widths and width helper for the PIO poll master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lab61soc_pio_pkg;

  localparam int AVM_DATA_W = 32;
  localparam int AVM_ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_READ = 2'd1,
    ST_EVAL = 2'd2
  } poll_state_e;

  // Bits needed to hold value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab61soc_pio_poll_master_if.sv
// ============================================================================
// Module : lab61soc_pio_poll_master_if
// Brief  : Avalon-MM read-only master/slave signal bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lab61soc_pio_poll_master_if;
  import lab61soc_pio_pkg::*;

  logic [AVM_ADDR_W-1:0] avm_address;
  logic                  avm_read;
  logic [AVM_DATA_W-1:0] avm_readdata;
  logic                  avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

`default_nettype wire

// File: rtl/lab61soc_pio_poll_master_debounce_core.sv
// ============================================================================
// Module : lab61soc_debounce_core
// Brief  : Whole-vector debounce with registered rise/fall event pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lab61soc_debounce_core
  import lab61soc_pio_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic [DATA_W-1:0] btn_state_o,
  output logic [DATA_W-1:0] rise_o,
  output logic [DATA_W-1:0] fall_o
);

  localparam int            CW      = clog2(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT - 1);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] btn_q,  btn_d;
  logic [DATA_W-1:0] rise_q, rise_d;
  logic [DATA_W-1:0] fall_q, fall_d;
  logic [CW-1:0]     cnt_q,  cnt_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    btn_d  = btn_q;
    if (strobe_i) begin
      // A single required sample means the new value is accepted immediately.
      if (DEBOUNCE_CNT == 1) begin
        cand_d = sample_i;
        cnt_d  = '0;
        btn_d  = sample_i;
      end else if (sample_i != cand_q) begin
        cand_d = sample_i;
        cnt_d  = '0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        btn_d = cand_q;
      end
    end
    rise_d = btn_d & ~btn_q;
    fall_d = ~btn_d & btn_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
      btn_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      btn_q  <= btn_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign btn_state_o = btn_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

`default_nettype wire

// File: rtl/lab61soc_pio_poll_master.sv
// ============================================================================
// Module : lab61soc_pio_poll_master
// Brief  : Periodic Avalon-MM poller of a PIO input with debounced outputs.
//          Optional read timeout / sticky bus_err under PIO_POLL_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lab61soc_pio_poll_master
  import lab61soc_pio_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int SLAVE_ADDR   = 0,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  lab61soc_pio_poll_master_if.master  avm,
  output logic [DATA_W-1:0]           btn_state,
  output logic [DATA_W-1:0]           rise_pulse,
  output logic [DATA_W-1:0]           fall_pulse,
  output logic                        sample_strobe,
  output logic                        bus_err
);

  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_READ = ST_READ;
  localparam logic [1:0] S_EVAL = ST_EVAL;

  localparam int            PW          = clog2(POLL_DIV);
  localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_DIV - 1);

  logic [1:0]        state_q,  state_d;
  logic [PW-1:0]     poll_q,   poll_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              w_accept;
  logic              w_timeout;
  logic              w_unused_hi;

  assign w_accept    = (state_q == S_READ) && !avm.avm_waitrequest;
  assign w_unused_hi = ^avm.avm_readdata;

`ifdef PIO_POLL_TIMEOUT_EN
  localparam int            TW     = clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;

  always_comb begin
    to_d      = '0;
    err_d     = err_q;
    w_timeout = 1'b0;
    if ((state_q == S_READ) && avm.avm_waitrequest) begin
      if (to_q == TO_MAX) begin
        w_timeout = 1'b1;
        err_d     = 1'b1;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign bus_err = err_q;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYC > 0);
  assign w_timeout   = 1'b0;
  assign bus_err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    poll_d   = poll_q;
    sample_d = sample_q;
    case (state_q)
      S_WAIT: begin
        if (poll_q == '0) begin
          state_d = S_READ;
          poll_d  = POLL_RELOAD;
        end else begin
          poll_d = poll_q - PW'(1);
        end
      end
      S_READ: begin
        if (w_accept) begin
          sample_d = avm.avm_readdata[DATA_W-1:0];
          state_d  = S_EVAL;
        end else if (w_timeout) begin
          state_d = S_WAIT;
        end
      end
      S_EVAL:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_WAIT;
      poll_q   <= POLL_RELOAD;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      poll_q   <= poll_d;
      sample_q <= sample_d;
    end
  end

  // Read strobe decodes directly from the state register, so it drops on
  // the edge that leaves READ (acceptance, timeout or reset).
  assign avm.avm_read    = (state_q == S_READ);
  assign avm.avm_address = AVM_ADDR_W'(SLAVE_ADDR);
  assign sample_strobe   = (state_q == S_EVAL);

  lab61soc_debounce_core #(
    .DATA_W       (DATA_W),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .strobe_i    (sample_strobe),
    .sample_i    (sample_q),
    .btn_state_o (btn_state),
    .rise_o      (rise_pulse),
    .fall_o      (fall_pulse)
  );

endmodule

`default_nettype wire

// File: tb/tb_lab61soc_pio_poll_master.sv
// ============================================================================
// Module : tb_lab61soc_pio_poll_master
// Brief  : Directed self-checking bench for the PIO poll master.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lab61soc_pio_poll_master;

  localparam int DATA_W       = 1;
  localparam int POLL_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int SLAVE_ADDR   = 0;
  localparam int TIMEOUT_CYC  = 8;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] btn_state;
  logic [DATA_W-1:0] rise_pulse;
  logic [DATA_W-1:0] fall_pulse;
  logic              sample_strobe;
  logic              bus_err;

  lab61soc_pio_poll_master_if bus ();

  lab61soc_pio_poll_master #(
    .DATA_W       (DATA_W),
    .POLL_DIV     (POLL_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .SLAVE_ADDR   (SLAVE_ADDR),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avm           (bus),
    .btn_state     (btn_state),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .sample_strobe (sample_strobe),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DATA_W-1:0] btn;
    logic [DATA_W-1:0] rise;
    logic [DATA_W-1:0] fall;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] m_cand;
  logic [DATA_W-1:0] m_btn;
  int                m_cnt;
  int                ncmp  = 0;
  int                nfail = 0;
  int                last_start;
  logic              exp_err;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_cand = '0;
    m_btn  = '0;
    m_cnt  = 0;
    sb_q.delete();
  endtask

  // Reference debounce: pushes the levels/pulses expected after one EVAL.
  task automatic model_push(input logic [DATA_W-1:0] s);
    exp_t              e;
    logic [DATA_W-1:0] nb;
    nb = m_btn;
    if (DEBOUNCE_CNT == 1) begin
      m_cand = s;
      nb     = s;
    end else if (s != m_cand) begin
      m_cand = s;
      m_cnt  = 0;
    end else if (m_cnt < DEBOUNCE_CNT - 1) begin
      m_cnt++;
    end else begin
      nb = m_cand;
    end
    e.btn  = nb;
    e.rise = nb & ~m_btn;
    e.fall = ~nb & m_btn;
    m_btn  = nb;
    sb_q.push_back(e);
  endtask

  task automatic wait_read;
    int n;
    n = 0;
    while (bus.avm_read !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    check("read_seen", {31'd0, bus.avm_read}, 32'd1);
  endtask

  // One poll: ws stall cycles (wrong data on the bus while stalled).
  task automatic poll(input logic [31:0] rd, input int ws, input int gap_exp);
    exp_t e;
    bus.avm_waitrequest = (ws > 0);
    bus.avm_readdata    = (ws > 0) ? ~rd : rd;
    wait_read();
    check("poll_gap", 32'(cyc - last_start), 32'(gap_exp));
    last_start = cyc;
    for (int i = 0; i < ws; i++) begin
      check("read_held", {31'd0, bus.avm_read}, 32'd1);
      check("addr_held", 32'(bus.avm_address), 32'(SLAVE_ADDR));
      check("no_strobe_stall", {31'd0, sample_strobe}, 32'd0);
      tick;
    end
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = rd;
    check("read_accept", {31'd0, bus.avm_read}, 32'd1);
    check("addr", 32'(bus.avm_address), 32'(SLAVE_ADDR));
    model_push(rd[DATA_W-1:0]);
    tick;
    bus.avm_readdata = 32'hDEAD_BEEF ^ rd;
    check("strobe", {31'd0, sample_strobe}, 32'd1);
    check("read_drop", {31'd0, bus.avm_read}, 32'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      tick;
      check("btn_state", 32'(btn_state), 32'(e.btn));
      check("rise_pulse", 32'(rise_pulse), 32'(e.rise));
      check("fall_pulse", 32'(fall_pulse), 32'(e.fall));
      check("strobe_one_cycle", {31'd0, sample_strobe}, 32'd0);
      tick;
      check("rise_clear", 32'(rise_pulse), 32'd0);
      check("fall_clear", 32'(fall_pulse), 32'd0);
      check("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
    end else begin
      check("sb_underflow", 32'd0, 32'd1);
    end
  endtask

  task automatic check_reset_outputs;
    check("rst_read", {31'd0, bus.avm_read}, 32'd0);
    check("rst_addr", 32'(bus.avm_address), 32'(SLAVE_ADDR));
    check("rst_btn", 32'(btn_state), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    check("rst_fall", 32'(fall_pulse), 32'd0);
    check("rst_strobe", {31'd0, sample_strobe}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    int n;
    bus.avm_readdata    = 32'd0;
    bus.avm_waitrequest = 1'b0;
    exp_err             = 1'b0;
    model_reset();

    // Reset and idle polling of a released button.
    reset = 1'b1;
    tick; tick; tick;
    check_reset_outputs();
    last_start = cyc;
    reset      = 1'b0;
    poll(32'h0000_0000, 0, POLL_DIV);
    poll(32'hFFFF_FFFE, 0, POLL_DIV + 2);

    // Stable press: accepted after the debounce window, single rise pulse.
    for (int i = 0; i < 4; i++) poll(32'h0000_0001, 0, POLL_DIV + 2);
    check("press_accepted", 32'(btn_state), 32'd1);

    // Stable release back to 0.
    for (int i = 0; i < 4; i++) poll(32'hFFFF_FFF0, 0, POLL_DIV + 2);
    check("release_accepted", 32'(btn_state), 32'd0);

    // Bounce 1,0,1,1: the 0 restarts the match count.
    poll(32'h1, 0, POLL_DIV + 2);
    poll(32'h0, 0, POLL_DIV + 2);
    poll(32'h1, 0, POLL_DIV + 2);
    poll(32'h1, 0, POLL_DIV + 2);
    check("bounce_held_low", 32'(btn_state), 32'd0);
    poll(32'h1, 0, POLL_DIV + 2);
    poll(32'h1, 0, POLL_DIV + 2);
    check("bounce_settled", 32'(btn_state), 32'd1);

    // Stalled read: capture only on the waitrequest=0 cycle.
    poll(32'h1, 3, POLL_DIV + 2);
    poll(32'h1, 0, POLL_DIV + 2 + 3);

    // Reset in the middle of a stalled read.
    bus.avm_waitrequest = 1'b1;
    wait_read();
    reset = 1'b1;
    tick;
    check_reset_outputs();
    tick;
    check("rst_no_strobe", {31'd0, sample_strobe}, 32'd0);
    last_start          = cyc;
    reset               = 1'b0;
    bus.avm_waitrequest = 1'b0;
    model_reset();
    poll(32'h1, 0, POLL_DIV);
    check("post_reset_btn", 32'(btn_state), 32'd0);

`ifdef PIO_POLL_TIMEOUT_EN
    // Waitrequest stuck high: abort after TIMEOUT_CYC, no EVAL.
    bus.avm_waitrequest = 1'b1;
    wait_read();
    check("to_gap", 32'(cyc - last_start), 32'(POLL_DIV + 2));
    last_start = cyc;
    n = 0;
    while (bus.avm_read === 1'b1 && n < 30) begin
      check("to_no_strobe", {31'd0, sample_strobe}, 32'd0);
      tick;
      n++;
    end
    check("to_read_cycles", 32'(n), 32'(TIMEOUT_CYC));
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_no_eval", {31'd0, sample_strobe}, 32'd0);
    bus.avm_waitrequest = 1'b0;
    exp_err             = 1'b1;
    poll(32'h1, 0, TIMEOUT_CYC + POLL_DIV);
    check("to_sticky", {31'd0, bus_err}, 32'd1);
`else
    n = 0;
    check("bus_err_tied", {31'd0, bus_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
